mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the RISC-V pipeline.
- Sits between the EX/MEM pipeline register (upstream) and the MEM/WB register (downstream).
- Non-memory instructions pass straight through.
- Loads and stores run a request/ack transaction on the data-memory bus through a small FSM. The FSM stalls the pipeline until the access completes.
- Formats load data (byte/half select, sign/zero extension) and generates store byte enables.

Parameters:
- DATA_W, 32, data and register width (fixed to 32 in this core).
- ADDR_W, 32, data-memory byte-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- wd_i  in  5  destination register from EX/MEM
- wreg_i  in  1  register-write enable from EX/MEM
- data_i  in  32  ALU result; effective byte address for loads/stores
- memop_i  in  4  memory op: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW
- store_data_i  in  32  rs2 value for stores
- wd_o  out  5  destination register to MEM/WB
- wreg_o  out  1  register-write enable to MEM/WB
- wdata_o  out  32  writeback data to MEM/WB
- stall_req_o  out  1  freezes PC/IF/ID/EX/MEM registers
- misalign_o  out  1  misaligned access flagged, single cycle
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  store data, lane-replicated
- dmem_ack_i  in  1  bus completion, one-cycle pulse
- dmem_rdata_i  in  32  read word, valid with ack

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
- On reset:
  - FSM goes to IDLE.
  - dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o = 0.
  - Captured read data = 0.
  - While rst=1, combinational outputs are forced: wreg_o=0, wd_o=0, wdata_o=0, stall_req_o=0, misalign_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, memop_i=NONE:
  - Pass-through: wd_o=wd_i, wreg_o=wreg_i, wdata_o=data_i, no stall.
- IDLE, misaligned op:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - misalign_o=1 and wreg_o=0.
  - No bus request, no stall, stay in IDLE.
- IDLE, aligned load/store:
  - stall_req_o=1 and wreg_o=0.
  - On the clock edge: register dmem_req_o=1 plus we/addr/be/wdata, then go to BUSY.
- BUSY:
  - stall_req_o=1 and wreg_o=0.
  - Request fields held stable.
  - On the edge where dmem_ack_i=1: capture dmem_rdata_i, clear dmem_req_o, go to DONE.
  - Wait indefinitely otherwise.
- DONE:
  - stall_req_o=0.
  - Load: wreg_o=wreg_i, wdata_o=formatted captured data.
  - Store: wreg_o=0.
  - Next state is IDLE; EX/MEM advances on the same edge.
- Minimum MEM occupancy for a load/store is 3 cycles (arrival, BUSY, DONE), i.e. 2 stall cycles.
- dmem_ack_i is ignored in IDLE and DONE.
- Upstream holds wd_i/wreg_i/data_i/memop_i/store_data_i constant while stall_req_o=1. The block samples them live and does not re-latch.
- Store formatting:
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated ×2.
  - SW: be = 4'b1111; wdata = store_data_i.
- Load formatting:
  - Select the byte/half lane by addr[1:0] / addr[1].
  - LB/LH sign-extend to 32; LBU/LHU zero-extend; LW passes the whole word.
- Reset mid-transaction: FSM returns to IDLE and the request drops. A late ack arriving after reset is ignored.

Decomposition:
- defines.v gains `MemOpBus (3:0) and encodings:
  - `MEM_NONE=0, `MEM_LB=1, `MEM_LH=2, `MEM_LW=3, `MEM_LBU=4, `MEM_LHU=5, `MEM_SB=6, `MEM_SH=7, `MEM_SW=8.
- defines.v also gains FSM state constants.
- Reuses `RegBus/`RegAddrBus/`RstEnable.
- One combinational sub-module, mem_load_fmt, takes (rdata, addr[1:0], memop) and returns the extended 32-bit result. Store formatting stays inline.

Test Plan:
1. memop=NONE, wd=5, wreg=1, data=0x1234 -> same-cycle wd_o=5, wreg_o=1, wdata_o=0x1234, stall_req_o=0, dmem_req_o never rises.
2. LB addr=0x103, ack on first BUSY cycle with rdata=0x80FF_FF00 -> stall high 2 cycles, dmem_addr_o=0x100, be=0000/we=0; DONE cycle wdata_o=0xFFFF_FF80, wreg_o=1.
3. LHU addr=0x202, rdata=0xBEEF_0000, ack delayed 4 cycles -> stall held 5 cycles, request fields stable throughout; DONE wdata_o=0x0000_BEEF.
4. SB addr=0x101, store_data=0xAB -> dmem_we_o=1, be=0010, wdata=0xABAB_ABAB; DONE wreg_o=0.
5. SH addr=0x101 -> misalign_o=1 for that cycle, wreg_o=0, no stall, no dmem_req_o.
6. SW issued, rst pulsed in BUSY, then ack after reset -> dmem_req_o=0 the cycle after rst; FSM in IDLE; late ack produces no DONE and no writeback.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared memory-op encodings, MEM-stage FSM states and store lane helpers
// for the RISC-V memory-access stage.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Byte enables for a store; loads request no lanes.
  function automatic logic [3:0] store_be(input mem_op_e op, input logic [1:0] addr);
    logic [3:0] be;
    be = 4'b0000;
    case (op)
      MEM_SB:  be = 4'b0001 << addr;
      MEM_SH:  be = addr[1] ? 4'b1100 : 4'b0011;
      MEM_SW:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated across lanes so the enables pick the right copy.
  function automatic logic [31:0] store_wdata(input mem_op_e op, input logic [31:0] data);
    logic [31:0] w;
    w = data;
    case (op)
      MEM_SB:  w = {4{data[7:0]}};
      MEM_SH:  w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// Load formatter: selects the byte/half lane of a read word and extends it.
module mem_load_fmt
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  mem_op_e     memop,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    result = rdata;
    case (memop)
      MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: result = {24'd0, byte_sel};
      MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: pass-through for ALU ops, request/ack data-memory FSM for
// loads and stores, with stall generation and load/store lane formatting.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [3:0]        memop_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stall_req_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i
);

  mem_state_e  state;
  mem_op_e     op;
  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic [31:0] rdata_q;
  logic [31:0] load_data;

  assign op       = mem_op_e'(memop_i);
  assign is_load  = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
                    (op == MEM_LBU) || (op == MEM_LHU);
  assign is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);

  always_comb begin
    misaligned = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: misaligned = data_i[0];
      MEM_LW, MEM_SW:          misaligned = (data_i[1:0] != 2'b00);
      default:                 misaligned = 1'b0;
    endcase
  end

  mem_load_fmt u_load_fmt (
    .rdata  (rdata_q),
    .addr   (data_i[1:0]),
    .memop  (op),
    .result (load_data)
  );

  // Bus request fields are registered on the launch edge and held until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= 4'b0000;
      dmem_wdata_o <= '0;
      rdata_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((is_load || is_store) && !misaligned) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= is_store;
            dmem_addr_o  <= {data_i[ADDR_W-1:2], 2'b00};
            dmem_be_o    <= store_be(op, data_i[1:0]);
            dmem_wdata_o <= is_store ? store_wdata(op, store_data_i) : '0;
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dmem_ack_i) begin
            rdata_q    <= dmem_rdata_i;
            dmem_req_o <= 1'b0;
            state      <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o        = wd_i;
    wreg_o      = 1'b0;
    wdata_o     = data_i;
    stall_req_o = 1'b0;
    misalign_o  = 1'b0;
    if (rst) begin
      wd_o    = 5'd0;
      wdata_o = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!(is_load || is_store)) wreg_o = wreg_i;
          else if (misaligned)        misalign_o = 1'b1;
          else                        stall_req_o = 1'b1;
        end
        ST_BUSY: stall_req_o = 1'b1;
        ST_DONE: begin
          if (is_load) begin
            wreg_o  = wreg_i;
            wdata_o = load_data;
          end
        end
        default: stall_req_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: pass-through and access vector tables,
// a writeback scoreboard, misalignment and mid-transaction reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd;
  logic        wreg;
  logic [31:0] data;
  logic [3:0]  memop;
  logic [31:0] store_data;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic        misalign_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .wd_i         (wd),
    .wreg_i       (wreg),
    .data_i       (data),
    .memop_i      (memop),
    .store_data_i (store_data),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .stall_req_o  (stall_req_o),
    .misalign_o   (misalign_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack),
    .dmem_rdata_i (dmem_rdata)
  );

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] data;
    logic [31:0] exp_wdata;
  } pass_vec_t;

  typedef struct {
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  wd;
    int          ack_delay;
    logic [31:0] rdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_bus_wdata;
    logic        exp_wreg;
    logic [31:0] exp_wdata;
  } access_vec_t;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } wb_t;

  wb_t sb_q[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input mem_op_e op, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [4:0] d,
                                input logic w);
    memop      = op;
    data       = addr;
    store_data = sdata;
    wd         = d;
    wreg       = w;
  endtask

  task automatic run_access(input access_vec_t v);
    int  busy_idx;
    int  stall_cycles;
    bit  done;
    wb_t exp;
    logic [31:0] exp_addr;
    exp_addr = v.addr & 32'hFFFF_FFFC;
    @(posedge clk); #1;
    apply_stimulus(v.op, v.addr, v.sdata, v.wd, 1'b1);
    dmem_ack = 1'b0;
    sb_q.push_back('{wd: v.wd, wreg: v.exp_wreg, wdata: v.exp_wdata});
    busy_idx = 0;
    stall_cycles = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
      if (!stall_req_o) begin
        done = 1'b1;
      end else begin
        stall_cycles++;
        check_output("stall_wreg", {31'd0, wreg_o}, 32'd0);
        if (stall_cycles == 1) check_output("arrival_req", {31'd0, dmem_req_o}, 32'd0);
        if (dmem_req_o) begin
          check_output("bus_addr", dmem_addr_o, exp_addr);
          check_output("bus_we", {31'd0, dmem_we_o}, {31'd0, v.exp_we});
          check_output("bus_be", {28'd0, dmem_be_o}, {28'd0, v.exp_be});
          check_output("bus_wdata", dmem_wdata_o, v.exp_bus_wdata);
          if (busy_idx == v.ack_delay) begin
            dmem_ack   = 1'b1;
            dmem_rdata = v.rdata;
          end
          busy_idx++;
        end
      end
    end
    if (!done) check_output("access_timeout", 32'd1, 32'd0);
    check_output("stall_cycles", stall_cycles, v.ack_delay + 2);
    check_output("done_req", {31'd0, dmem_req_o}, 32'd0);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check_output("done_wd", {27'd0, wd_o}, {27'd0, exp.wd});
      check_output("done_wreg", {31'd0, wreg_o}, {31'd0, exp.wreg});
      if (exp.wreg) check_output("done_wdata", wdata_o, exp.wdata);
    end
    @(posedge clk); #1;
    apply_stimulus(MEM_NONE, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  pass_vec_t   pass_tab[4];
  access_vec_t acc_tab[9];

  initial begin
    pass_tab[0] = '{wd: 5'd5,  wreg: 1'b1, data: 32'h0000_1234, exp_wdata: 32'h0000_1234};
    pass_tab[1] = '{wd: 5'd31, wreg: 1'b0, data: 32'hFFFF_FFFF, exp_wdata: 32'hFFFF_FFFF};
    pass_tab[2] = '{wd: 5'd0,  wreg: 1'b1, data: 32'h0000_0000, exp_wdata: 32'h0000_0000};
    pass_tab[3] = '{wd: 5'd17, wreg: 1'b1, data: 32'h8000_0003, exp_wdata: 32'h8000_0003};

    acc_tab[0] = '{MEM_LB,  32'h0000_0103, 32'h0,         5'd1, 0, 32'h80FF_FF00, 1'b0, 4'b0000, 32'h0,         1'b1, 32'hFFFF_FF80};
    acc_tab[1] = '{MEM_LHU, 32'h0000_0202, 32'h0,         5'd2, 3, 32'hBEEF_0000, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0000_BEEF};
    acc_tab[2] = '{MEM_SB,  32'h0000_0101, 32'h0000_00AB, 5'd3, 0, 32'h0,         1'b1, 4'b0010, 32'hABAB_ABAB, 1'b0, 32'h0};
    acc_tab[3] = '{MEM_LH,  32'h0000_0102, 32'h0,         5'd4, 1, 32'h7FFE_1234, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0000_7FFE};
    acc_tab[4] = '{MEM_LH,  32'h0000_0100, 32'h0,         5'd5, 2, 32'h0000_8001, 1'b0, 4'b0000, 32'h0,         1'b1, 32'hFFFF_8001};
    acc_tab[5] = '{MEM_LBU, 32'h0000_0101, 32'h0,         5'd6, 0, 32'h1234_F600, 1'b0, 4'b0000, 32'h0,         1'b1, 32'h0000_00F6};
    acc_tab[6] = '{MEM_LW,  32'h0000_010C, 32'h0,         5'd7, 0, 32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0,         1'b1, 32'hDEAD_BEEF};
    acc_tab[7] = '{MEM_SH,  32'h0000_0202, 32'h1234_5678, 5'd8, 1, 32'h0,         1'b1, 4'b1100, 32'h5678_5678, 1'b0, 32'h0};
    acc_tab[8] = '{MEM_SW,  32'h0000_0300, 32'hCAFE_F00D, 5'd9, 2, 32'h0,         1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};

    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    apply_stimulus(MEM_NONE, 32'h55, 32'h0, 5'd7, 1'b1);

    @(negedge clk);
    @(negedge clk);
    check_output("rst_wd", {27'd0, wd_o}, 32'd0);
    check_output("rst_wreg", {31'd0, wreg_o}, 32'd0);
    check_output("rst_wdata", wdata_o, 32'd0);
    check_output("rst_stall", {31'd0, stall_req_o}, 32'd0);
    check_output("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check_output("rst_be", {28'd0, dmem_be_o}, 32'd0);
    check_output("rst_addr", dmem_addr_o, 32'd0);
    rst = 1'b0;

    foreach (pass_tab[i]) begin
      @(posedge clk); #1;
      apply_stimulus(MEM_NONE, pass_tab[i].data, 32'h0, pass_tab[i].wd, pass_tab[i].wreg);
      @(negedge clk);
      check_output("pass_wd", {27'd0, wd_o}, {27'd0, pass_tab[i].wd});
      check_output("pass_wreg", {31'd0, wreg_o}, {31'd0, pass_tab[i].wreg});
      check_output("pass_wdata", wdata_o, pass_tab[i].exp_wdata);
      check_output("pass_stall", {31'd0, stall_req_o}, 32'd0);
      check_output("pass_req", {31'd0, dmem_req_o}, 32'd0);
    end

    for (int i = 0; i < 9; i++) run_access(acc_tab[i]);

    // Misaligned accesses flag for one cycle and never reach the bus.
    begin
      mem_op_e     mis_op[4];
      logic [31:0] mis_addr[4];
      mis_op[0] = MEM_SH;  mis_addr[0] = 32'h0000_0101;
      mis_op[1] = MEM_LW;  mis_addr[1] = 32'h0000_0102;
      mis_op[2] = MEM_LHU; mis_addr[2] = 32'h0000_0203;
      mis_op[3] = MEM_SW;  mis_addr[3] = 32'h0000_0001;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        apply_stimulus(mis_op[i], mis_addr[i], 32'h1234_5678, 5'd10, 1'b1);
        @(negedge clk);
        check_output("mis_flag", {31'd0, misalign_o}, 32'd1);
        check_output("mis_wreg", {31'd0, wreg_o}, 32'd0);
        check_output("mis_stall", {31'd0, stall_req_o}, 32'd0);
        @(posedge clk); #1;
        apply_stimulus(MEM_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        check_output("mis_req", {31'd0, dmem_req_o}, 32'd0);
        check_output("mis_flag_clear", {31'd0, misalign_o}, 32'd0);
      end
    end

    // Reset during BUSY, then a late ack that must be ignored.
    @(posedge clk); #1;
    apply_stimulus(MEM_SW, 32'h0000_0400, 32'h0000_0001, 5'd12, 1'b0);
    @(negedge clk);
    check_output("rstmid_arrival_stall", {31'd0, stall_req_o}, 32'd1);
    @(negedge clk);
    check_output("rstmid_busy_req", {31'd0, dmem_req_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_output("rstmid_req", {31'd0, dmem_req_o}, 32'd0);
    check_output("rstmid_stall", {31'd0, stall_req_o}, 32'd0);
    rst = 1'b0;
    apply_stimulus(MEM_NONE, 32'h0000_0077, 32'h0, 5'd3, 1'b1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    check_output("late_ack_req", {31'd0, dmem_req_o}, 32'd0);
    check_output("late_ack_stall", {31'd0, stall_req_o}, 32'd0);
    check_output("late_ack_wreg", {31'd0, wreg_o}, 32'd1);
    check_output("late_ack_wdata", wdata_o, 32'h0000_0077);
    @(negedge clk);
    check_output("late_ack_idle_stall", {31'd0, stall_req_o}, 32'd0);
    check_output("late_ack_idle_wdata", wdata_o, 32'h0000_0077);

    // Back-to-back access after the reset proves the FSM restarted cleanly.
    run_access(acc_tab[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=%h required=%h", 32'd1, 32'd0);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
